// File: rtl/fmap_buffer.sv
// Ping-pong feature-map buffer: captures one pooled map per bank from a
// non-backpressurable producer while the other bank drains over valid/ready.
module fmap_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int FMAP_SIZE  = 13
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  in_valid,
    input  logic                  in_end,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow,
    output logic [7:0]            frame_cnt
);

    localparam int DEPTH = FMAP_SIZE * FMAP_SIZE;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t           state_q [2];
    bank_state_t           state_d [2];
    logic                  wsel;
    logic                  rsel;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic accept;
    logic can_write;
    logic do_write;
    logic drop;
    logic wr_last;
    logic rd_valid;
    logic rd_last;
    logic xfer;

    // Write and read sides only ever touch different banks in the same cycle,
    // since a bank is writable only when EMPTY/FILLING and readable only when FULL/DRAINING.
    always_comb begin
        accept    = in_valid && !in_end;
        can_write = (state_q[wsel] == EMPTY) || (state_q[wsel] == FILLING);
        do_write  = accept && can_write;
        drop      = accept && !can_write;
        wr_last   = (wr_ptr == LAST_IDX);
        rd_valid  = (state_q[rsel] == FULL) || (state_q[rsel] == DRAINING);
        rd_last   = (rd_ptr == LAST_IDX);
        xfer      = rd_valid && out_ready;
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= EMPTY;
            end
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
            end
            if (do_write) begin
                if (wr_last) begin
                    wr_ptr <= '0;
                    wsel   <= ~wsel;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                if (rd_last) begin
                    rd_ptr    <= '0;
                    rsel      <= ~rsel;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wsel][wr_ptr] <= in_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            if (do_write && (wsel == 1'(i))) begin
                state_d[i] = wr_last ? FULL : FILLING;
            end
            if (xfer && (rsel == 1'(i))) begin
                state_d[i] = rd_last ? EMPTY : DRAINING;
            end
        end
    end

    always_comb begin
        out_valid = rd_valid;
        out_last  = rd_valid && rd_last;
        out_data  = '0;
        if (rd_valid) begin
            out_data = mem[rsel][rd_ptr];
        end
    end

endmodule

// File: tb/tb_fmap_buffer.sv
// Bench for fmap_buffer (2x2 maps): directed scenarios plus random traffic,
// checked every cycle against a queue-based reference of buffered words.
module tb_fmap_buffer;

    localparam int DW    = 16;
    localparam int FS    = 2;
    localparam int DEPTH = FS * FS;

    logic          clk;
    logic          global_rst_n;
    logic          in_valid;
    logic          in_end;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          overflow;
    logic [7:0]    frame_cnt;

    int n_tests;
    int n_fail;

    // Reference: completed-but-unsent words in raster order, plus the map being filled.
    int stored[$];
    int partial[$];
    bit m_ovf;
    int m_frames;

    fmap_buffer #(.DATA_WIDTH(DW), .FMAP_SIZE(FS)) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .in_valid     (in_valid),
        .in_end       (in_end),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        stored.delete();
        partial.delete();
        m_ovf    = 1'b0;
        m_frames = 0;
    endtask

    task automatic check_outputs();
        bit has;
        has = stored.size() > 0;
        chk("out_valid", 32'(out_valid), 32'(has));
        chk("out_data",  32'(out_data),  has ? 32'(stored[0]) : 32'd0);
        chk("out_last",  32'(out_last),  32'(has && (stored.size() % DEPTH == 1)));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    endtask

    // One clock: drive inputs, decide from the pre-edge view, apply after the edge.
    task automatic step(input logic v, input logic e, input logic [DW-1:0] d, input logic r);
        int occ;
        bit has;
        bit last;
        bit xfer;
        in_valid  = v;
        in_end    = e;
        in_data   = d;
        out_ready = r;
        occ  = (stored.size() + DEPTH - 1) / DEPTH;
        has  = stored.size() > 0;
        last = has && (stored.size() % DEPTH == 1);
        xfer = has && r;
        @(posedge clk);
        #1;
        if (xfer) begin
            void'(stored.pop_front());
            if (last) m_frames = (m_frames + 1) % 256;
        end
        if (v && !e) begin
            if (occ < 2) begin
                partial.push_back(int'(d));
                if (partial.size() == DEPTH) begin
                    foreach (partial[i]) stored.push_back(partial[i]);
                    partial.delete();
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        global_rst_n = 1'b0;
        in_valid     = 1'b0;
        in_end       = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        #7;
        check_outputs();
        @(negedge clk);
        global_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single map
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i), 1'b1);
        chk("single_first_word", 32'(out_data), 32'd1);
        idle(5, 1'b1);
        chk("single_frames", 32'(frame_cnt), 32'd1);

        // Ping-pong, continuous stream
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(16'h10 + i), 1'b1);
        idle(6, 1'b1);
        chk("pingpong_frames", 32'(frame_cnt), 32'd3);

        // end_op filtering
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 16'hFFFF, 1'b1);
            step(1'b1, 1'b0, DW'(i), 1'b1);
        end
        idle(6, 1'b1);

        // Stall mid-map
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(16'h20 + i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("stall_hold", 32'(out_data), 32'h22);
        end
        idle(5, 1'b1);

        // Backpressure / overflow
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(16'hA0 + i), 1'b0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        idle(10, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-map
        step(1'b1, 1'b0, 16'h5A, 1'b1);
        step(1'b1, 1'b0, 16'h5B, 1'b1);
        in_valid = 1'b0;
        #3;
        global_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        global_rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 5; i <= 8; i++) step(1'b1, 1'b0, DW'(i), 1'b1);
        idle(5, 1'b1);
        chk("reset_frames", 32'(frame_cnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                 DW'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        idle(12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fmap_buffer.md
# fmap_buffer

Ping-pong feature-map buffer sitting directly downstream of `layer`. It captures the pooled output stream (`data_out`/`valid_op`/`end_op`) of one complete feature map into one bank while the other bank is drained to the next stage through a valid/ready handshake. `layer` has no backpressure, so the block absorbs one full map of slack and flags any sample it is forced to drop.

## Interface
- `DATA_WIDTH`, 16: sample width. Matches `layer` `DATA_WIDTH`.
- `FMAP_SIZE`, 13: pooled map side, `(INPUT_SIZE-KERNEL_SIZE+1)/POOL_SIZE`. Local `DEPTH = FMAP_SIZE*FMAP_SIZE` words per bank.
- `clk` in 1: single clock; all state updates on rising edge.
- `global_rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: sample strobe, driven from `layer.valid_op`.
- `in_end` in 1: driven from `layer.end_op`.
- `in_data` in DATA_WIDTH: driven from `layer.data_out`.
- `out_valid` out 1: `out_data` holds a buffered sample.
- `out_ready` in 1: consumer accepts the sample.
- `out_data` out DATA_WIDTH: sample in raster order; forced to 0 when `out_valid`=0.
- `out_last` out 1: marks the final word (index DEPTH-1) of a map.
- `overflow` out 1: sticky; a sample was dropped.
- `frame_cnt` out 8: number of maps fully drained; wraps at 255→0.

## Operation
- Storage: two banks of DEPTH×DATA_WIDTH registers. Memory contents are not reset.
- Each bank has a state: EMPTY, FILLING, FULL or DRAINING.
- Write bank select `wsel`; write pointer `wr_ptr` runs 0..DEPTH-1.
- Read bank select `rsel`; read pointer `rd_ptr` runs 0..DEPTH-1.
- **Accepted sample:** `in_valid`=1 and `in_end`=0.
  - Samples with `in_end`=1 are ignored and never stored.
- **Write:** an accepted sample is written to `bank[wsel][wr_ptr]` when that bank is EMPTY or FILLING.
  - EMPTY→FILLING on the first write.
  - On the write with `wr_ptr`=DEPTH-1: bank→FULL, `wr_ptr`→0, `wsel` toggles.
- **Drop:** an accepted sample arriving while `bank[wsel]` is FULL or DRAINING is dropped and `overflow` sets.
  - `overflow` is cleared only by reset.
  - `wr_ptr` does not advance on a drop.
- **Read:** `out_valid`=1 while `bank[rsel]` is FULL or DRAINING.
  - `out_data` = `bank[rsel][rd_ptr]`, a combinational read of the registered array.
  - `out_last` = `out_valid` && `rd_ptr`==DEPTH-1.
- **Read handshake:** a transfer occurs on the edge where `out_valid` && `out_ready`.
  - First transfer: FULL→DRAINING.
  - Each transfer advances `rd_ptr`.
  - Transfer with `out_last`=1: bank→EMPTY, `rd_ptr`→0, `rsel` toggles, `frame_cnt`+1.
- Banks are consumed strictly in fill order, so maps are never reordered.
- **Simultaneous events:**
  - Write into one bank and read from the other in the same cycle are independent; both take effect.
  - Final read of bank B on the same edge as the first write to B is impossible by construction: B is not EMPTY until the edge after its last read. A sample arriving on that edge is dropped.
- **Reset mid-operation:**
  - Both banks→EMPTY; `wsel`, `rsel`, `wr_ptr`, `rd_ptr`→0.
  - `overflow`, `frame_cnt`, `out_valid`, `out_last`→0; `out_data`→0.
  - Any partial map is discarded.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `overflow`=0, `frame_cnt`=0.
- **Fill-to-output latency:** the DEPTH-th write lands at edge N. `out_valid` rises after edge N, combinationally from the bank state. Word 0 is available in cycle N+1 when the read side is idle.
- **Throughput:**
  - Write: one sample per cycle.
  - Read: one word per cycle with `out_ready` held high. A full map drains in DEPTH cycles.
- **Handshake stability:** once `out_valid`=1, `out_data`/`out_last` stay stable until the transfer.
  - The consumer may hold `out_ready`=1 continuously.
  - `out_ready` while `out_valid`=0 has no effect.
- `overflow` asserts the cycle after the edge on which the drop occurred.

## Test plan
- **Single map** (FMAP_SIZE=2, DEPTH=4): write 0x0001..0x0004 back-to-back, `out_ready`=1.
  - Expect `out_data` 1,2,3,4 on four consecutive cycles starting the cycle after the 4th write.
  - `out_last` only on 4.
  - `frame_cnt`=1; `overflow`=0.
- **Ping-pong:** stream 8 samples 0x10..0x17 continuously with `out_ready`=1.
  - Output order is 0x10..0x17 with no gaps after the first word.
  - `frame_cnt`=2; no overflow.
- **Backpressure/overflow:** `out_ready`=0, write 9 samples 0xA0..0xA8.
  - Banks hold 0xA0..0xA3 and 0xA4..0xA7; 0xA8 is dropped and `overflow`=1.
  - Raise `out_ready`: output is exactly 0xA0..0xA7, then `out_valid`=0.
- **end_op filtering:** interleave 4 samples having `in_end`=1 (value 0xFFFF) among 4 valid ones (1..4).
  - Output is 1,2,3,4; 0xFFFF never appears.
- **Stall mid-map:** drop `out_ready` after word 1 for 5 cycles.
  - `out_data` is held at word 2 with `out_valid`=1; the sequence resumes unchanged.
- **Reset mid-operation:** assert `global_rst_n`=0 asynchronously after 2 of 4 writes.
  - All outputs go 0 immediately.
  - A following 4-sample map 5..8 outputs 5,6,7,8 with `frame_cnt`=1.
